// File: rtl/riscv_dbg_pkg.sv
// Shared command encodings and controller state enumeration for the debug controller.
package riscv_dbg_pkg;

  typedef enum logic [2:0] {
    OP_LOAD_IMEM = 3'd0,
    OP_WRITE_REG = 3'd1,
    OP_SET_BP    = 3'd2,
    OP_RUN       = 3'd3,
    OP_DUMP      = 3'd4
  } dbg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RUN,
    ST_DUMP
  } dbg_state_e;

  localparam int unsigned OP_W = 3;

  // True for the five defined command opcodes.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/dbg_cycle_counter.sv
// Run-budget down-counter paired with an elapsed-cycle up-counter.
module dbg_cycle_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          expire
);

  logic [CW-1:0] remaining;

  // Load restarts the budget and clears elapsed count; enable consumes one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      count     <= '0;
    end else if (load) begin
      remaining <= load_val;
      count     <= '0;
    end else if (en) begin
      remaining <= remaining - CW'(1);
      count     <= count + CW'(1);
    end
  end

  // Expiry flags the last enabled cycle of the budget.
  assign expire = en && (remaining == CW'(1));

endmodule

// File: rtl/riscv_debug_ctrl.sv
// Debug controller: loads imem/regfile, runs the core for a budget or until a
// breakpoint, and streams the register file out.
module riscv_debug_ctrl
  import riscv_dbg_pkg::*;
#(
  parameter  int unsigned XLEN       = 32,
  parameter  int unsigned IMEM_DEPTH = 256,
  parameter  int unsigned NREG       = 32,
  parameter  int unsigned CW         = 16,
  localparam int unsigned IAW        = $clog2(IMEM_DEPTH),
  localparam int unsigned RAW        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  // One bit wider than the imem index so out-of-range addresses are representable.
  input  logic [IAW:0]    cmd_addr,
  input  logic [XLEN-1:0] cmd_data,
  output logic            core_reset,
  input  logic [XLEN-1:0] core_pc,
  output logic            imem_we,
  output logic [IAW-1:0]  imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [RAW-1:0]  rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [RAW-1:0]  dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            busy,
  output logic            done,
  output logic            hit_bp,
  output logic            err,
  output logic [CW-1:0]   cycle_count
);

  localparam logic [IAW:0]   IMEM_LIMIT = (IAW+1)'(IMEM_DEPTH);
  localparam logic [RAW-1:0] LAST_IDX   = RAW'(NREG - 1);

  dbg_state_e      state;
  logic [XLEN-1:0] bp_addr;
  logic            bp_en;

  logic            accept;
  logic            run_load;
  logic            run_en;
  logic            expire;
  logic            bp_match;
  logic            imem_addr_ok;
  logic            dump_fire;
  logic [RAW-1:0]  rf_idx;
  logic [CW-1:0]   budget;

  assign accept       = cmd_valid && cmd_ready;
  assign run_load     = accept && (cmd_op == OP_RUN);
  assign run_en       = (state == ST_RUN);
  assign bp_match     = bp_en && (core_pc == bp_addr);
  assign imem_addr_ok = (cmd_addr < IMEM_LIMIT);
  assign dump_fire    = dump_valid && dump_ready;
  assign rf_idx       = cmd_addr[RAW-1:0];
  assign budget       = cmd_data[CW-1:0];

  assign rf_raddr  = dump_idx;
  assign dump_data = rf_rdata;

  dbg_cycle_counter #(.CW(CW)) u_cycle_counter (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (run_load),
    .load_val (budget),
    .en       (run_en),
    .count    (cycle_count),
    .expire   (expire)
  );

  // Command FSM with registered handshake, write-port, core-reset and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      core_reset <= 1'b1;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit_bp     <= 1'b0;
      err        <= 1'b0;
      bp_en      <= 1'b0;
      bp_addr    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            case (cmd_op)
              OP_LOAD_IMEM: begin
                if (imem_addr_ok) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= cmd_addr[IAW-1:0];
                  imem_wdata <= cmd_data;
                  state      <= ST_WRITE;
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_WRITE_REG: begin
                rf_we     <= (rf_idx != '0);
                rf_waddr  <= rf_idx;
                rf_wdata  <= cmd_data;
                state     <= ST_WRITE;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              OP_SET_BP: begin
                bp_addr <= cmd_data;
                bp_en   <= 1'b1;
              end
              OP_RUN: begin
                hit_bp <= 1'b0;
                if (budget != '0) begin
                  state      <= ST_RUN;
                  core_reset <= 1'b0;
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
                end else begin
                  done <= 1'b1;
                end
              end
              OP_DUMP: begin
                dump_valid <= 1'b1;
                dump_idx   <= RAW'(1);
                state      <= ST_DUMP;
                cmd_ready  <= 1'b0;
                busy       <= 1'b1;
              end
              default: begin
                if (!op_is_legal(cmd_op)) err <= 1'b1;
              end
            endcase
          end
        end
        ST_WRITE: begin
          imem_we   <= 1'b0;
          rf_we     <= 1'b0;
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        ST_RUN: begin
          if (bp_match || expire) begin
            core_reset <= 1'b1;
            hit_bp     <= bp_match;
            done       <= 1'b1;
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        ST_DUMP: begin
          if (dump_fire) begin
            if (dump_idx == LAST_IDX) begin
              dump_valid <= 1'b0;
              done       <= 1'b1;
              state      <= ST_IDLE;
              cmd_ready  <= 1'b1;
              busy       <= 1'b0;
            end else begin
              dump_idx <= dump_idx + RAW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_debug_ctrl.sv
// Self-checking bench for riscv_debug_ctrl with a tiny ADD-only core model.
module tb_riscv_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        core_reset;
  logic [31:0] core_pc;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;
  logic        hit_bp;
  logic        err;
  logic [15:0] cycle_count;

  riscv_debug_ctrl #(.XLEN(32), .IMEM_DEPTH(256), .NREG(32), .CW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .core_reset(core_reset), .core_pc(core_pc),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .busy(busy), .done(done), .hit_bp(hit_bp), .err(err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Environment: imem, register file and a core that executes R-type ADDs.
  logic [31:0] imem_m [256];
  logic [31:0] rf_m [32];
  logic [31:0] pc = '0;
  logic [31:0] instr;

  initial begin
    for (int i = 0; i < 256; i++) imem_m[i] = '0;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
  end

  always @(posedge clk) begin
    if (imem_we) imem_m[imem_addr] <= imem_wdata;
    if (rf_we) rf_m[rf_waddr] <= rf_wdata;
    if (core_reset) begin
      pc <= '0;
    end else begin
      instr = imem_m[pc[9:2]];
      if (instr[6:0] == 7'h33 && instr[14:12] == 3'd0 && instr[31:25] == 7'd0 && instr[11:7] != 5'd0)
        rf_m[instr[11:7]] <= rf_m[instr[19:15]] + rf_m[instr[24:20]];
      pc <= pc + 32'd4;
    end
  end

  assign core_pc  = pc;
  assign rf_rdata = rf_m[rf_raddr];

  // Write-port monitors sampled on the falling edge.
  int unsigned imem_cnt = 0, rf_cnt = 0;
  logic [31:0] imem_a, imem_d, rf_a, rf_d;
  always @(negedge clk) begin
    if (imem_we) begin imem_cnt++; imem_a = 32'(imem_addr); imem_d = imem_wdata; end
    if (rf_we) begin rf_cnt++; rf_a = 32'(rf_waddr); rf_d = rf_wdata; end
  end

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [8:0] addr, input logic [31:0] data);
    int unsigned w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Reference: cycle k of a run (1-based) executes with PC = 4*(k-1).
  task automatic predict(input int unsigned n, input logic en, input int unsigned bp,
                         output int unsigned cnt, output logic hit);
    cnt = n;
    hit = 1'b0;
    if (en) begin
      for (int unsigned k = 1; k <= n; k++) begin
        if (4 * (k - 1) == bp) begin
          cnt = k;
          hit = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic run_check(input int unsigned n, input int unsigned exp_cnt, input logic exp_hit,
                           input string tag);
    int unsigned lows = 0, done_n = 0, done_at = 0;
    send_cmd(3'd3, 9'd0, n);
    for (int unsigned cyc = 1; cyc <= n + 20; cyc++) begin
      @(negedge clk);
      if (!core_reset) lows++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = cyc;
      end
    end
    check({tag, "_lows"}, 64'(lows), 64'(exp_cnt));
    check({tag, "_done_n"}, 64'(done_n), 64'd1);
    check({tag, "_done_at"}, 64'(done_at), 64'(exp_cnt + 1));
    check({tag, "_cycle_count"}, 64'(cycle_count), 64'(exp_cnt));
    check({tag, "_hit_bp"}, 64'(hit_bp), 64'(exp_hit));
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [8:0]  addr;
    logic [31:0] data;
    int unsigned n_imem;
    int unsigned n_rf;
    logic        busy_after;
    logic        err_after;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_cnt;
    logic        exp_hit;
    logic        bp_on;
    int unsigned bp_val;
    int unsigned n;
    logic [31:0] exp_rf [32];

    vecs[0] = '{3'd0, 9'd0,   32'h005303b3, 1, 0, 1'b1, 1'b0};
    vecs[1] = '{3'd0, 9'd1,   32'h00628633, 1, 0, 1'b1, 1'b0};
    vecs[2] = '{3'd1, 9'd5,   32'h00000001, 0, 1, 1'b1, 1'b0};
    vecs[3] = '{3'd1, 9'd6,   32'h00000002, 0, 1, 1'b1, 1'b0};
    vecs[4] = '{3'd1, 9'd0,   32'hFFFFFFFF, 0, 0, 1'b1, 1'b0};
    vecs[5] = '{3'd0, 9'd256, 32'h12345678, 0, 0, 1'b0, 1'b1};
    vecs[6] = '{3'd7, 9'd3,   32'hDEADBEEF, 0, 0, 1'b0, 1'b1};

    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    exp_rf[5]  = 32'd1;
    exp_rf[6]  = 32'd2;
    exp_rf[7]  = 32'd3;
    exp_rf[12] = 32'd3;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hit_bp", 64'(hit_bp), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_dump_valid", 64'(dump_valid), 64'd0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Table-driven load/write/illegal commands.
    for (int i = 0; i < 7; i++) begin
      imem_cnt = 0;
      rf_cnt   = 0;
      send_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].busy_after));
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_imem_we_n", i), 64'(imem_cnt), 64'(vecs[i].n_imem));
      check($sformatf("vec%0d_rf_we_n", i), 64'(rf_cnt), 64'(vecs[i].n_rf));
      check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err_after));
      if (vecs[i].n_imem != 0) begin
        check($sformatf("vec%0d_imem_addr", i), 64'(imem_a), 64'(vecs[i].addr));
        check($sformatf("vec%0d_imem_data", i), 64'(imem_d), 64'(vecs[i].data));
      end
      if (vecs[i].n_rf != 0) begin
        check($sformatf("vec%0d_rf_addr", i), 64'(rf_a), 64'(vecs[i].addr));
        check($sformatf("vec%0d_rf_data", i), 64'(rf_d), 64'(vecs[i].data));
      end
    end

    // Budgeted runs with breakpoints disabled.
    bp_on  = 1'b0;
    bp_val = 0;
    run_check(5, 5, 1'b0, "run5");
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(0, 30);
      predict(n, bp_on, bp_val, exp_cnt, exp_hit);
      run_check(n, exp_cnt, exp_hit, $sformatf("rnd_nobp%0d", i));
    end

    // Breakpoint at 0x4 on the two-ADD program.
    send_cmd(3'd2, 9'd0, 32'h4);
    bp_on  = 1'b1;
    bp_val = 4;
    @(negedge clk);
    check("setbp_cmd_ready", 64'(cmd_ready), 64'd1);
    check("setbp_busy", 64'(busy), 64'd0);
    predict(100, bp_on, bp_val, exp_cnt, exp_hit);
    run_check(100, exp_cnt, exp_hit, "run_bp4");

    // Random breakpoints and budgets against the reference.
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0) bp_val = $urandom_range(0, 200);
      else bp_val = 4 * $urandom_range(0, 20);
      n = $urandom_range(0, 30);
      send_cmd(3'd2, 9'd0, bp_val);
      predict(n, bp_on, bp_val, exp_cnt, exp_hit);
      run_check(n, exp_cnt, exp_hit, $sformatf("rnd_bp%0d", i));
    end
    // Budget expiry coinciding with breakpoint match.
    send_cmd(3'd2, 9'd0, 32'd16);
    run_check(5, 5, 1'b1, "bp_at_expiry");

    // Register dump with dump_ready toggling every other cycle.
    begin
      int unsigned exp_idx = 1, beats = 0, last_at = 0, done_at = 0, done_n = 0;
      logic        prev_stall = 1'b0;
      logic [4:0]  st_idx = '0;
      logic [31:0] st_data = '0;
      send_cmd(3'd4, 9'd0, 32'd0);
      for (int unsigned cyc = 1; cyc <= 120; cyc++) begin
        @(negedge clk);
        dump_ready = cyc[0];
        #1;
        if (done) begin
          done_n++;
          done_at = cyc;
        end
        if (dump_valid) begin
          if (prev_stall) begin
            check($sformatf("dump_stable_idx_c%0d", cyc), 64'(dump_idx), 64'(st_idx));
            check($sformatf("dump_stable_data_c%0d", cyc), 64'(dump_data), 64'(st_data));
          end
          if (dump_ready) begin
            beats++;
            check($sformatf("dump_idx_b%0d", beats), 64'(dump_idx), 64'(exp_idx));
            check($sformatf("dump_data_b%0d", beats), 64'(dump_data), 64'(exp_rf[exp_idx[4:0]]));
            if (exp_idx == 31) last_at = cyc;
            exp_idx++;
            prev_stall = 1'b0;
          end else begin
            prev_stall = 1'b1;
            st_idx  = dump_idx;
            st_data = dump_data;
          end
        end
      end
      dump_ready = 1'b0;
      check("dump_beats", 64'(beats), 64'd31);
      check("dump_done_n", 64'(done_n), 64'd1);
      check("dump_done_at", 64'(done_at), 64'(last_at + 1));
      check("dump_busy_after", 64'(busy), 64'd0);
    end

    // Reset asserted mid-RUN, with a breakpoint armed that reset must clear.
    begin
      int unsigned done_n = 0;
      send_cmd(3'd2, 9'd0, 32'd200);
      send_cmd(3'd3, 9'd0, 32'd60);
      repeat (3) @(negedge clk);
      check("midrst_running", 64'(core_reset), 64'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_core_reset", 64'(core_reset), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("midrst_cycle_count", 64'(cycle_count), 64'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done) done_n++;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done) done_n++;
      end
      check("midrst_no_done", 64'(done_n), 64'd0);
      check("midrst_cmd_ready_after", 64'(cmd_ready), 64'd1);
      check("midrst_err_cleared", 64'(err), 64'd0);
      check("midrst_hit_bp", 64'(hit_bp), 64'd0);
    end
    run_check(60, 60, 1'b0, "post_rst_bp_disabled");

    // Illegal opcode from a clean err state.
    send_cmd(3'd5, 9'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("illegal_op_err", 64'(err), 64'd1);
    check("illegal_op_idle", 64'(cmd_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
